if_stage: RTL and testbench
===========================

Name: if_stage

Overview:
- Instruction-fetch stage of the 5-stage RISC-V pipeline.
- Combines three pieces:
  - the program-counter register;
  - the PC+4 incrementer;
  - the IF/ID pipeline register.
- Drives the fetch address to the external instruction memory, which is combinational.
- Captures the returned instruction and PC+4 for the decode stage.
- Supports stall, flush and branch/jump redirect.

Parameters:
- XLEN, 32, datapath/address width.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- PC_INC, 4, increment applied each fetch.
- NOP_INSTR, 32'h0000_0013, instruction injected on reset or flush (addi x0,x0,0).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous active-low reset (0 = reset asserted).
- instruction  input  XLEN  instruction word returned by imem for address PC.
- stall  input  1  hold PC and IF/ID contents.
- flush  input  1  replace IF/ID contents with a bubble.
- branch_taken  input  1  redirect PC to branch_target.
- branch_target  input  XLEN  redirect address.
- PC  output  XLEN  current fetch address, to imem.
- PC_new  output  XLEN  combinational PC + PC_INC.
- instr  output  XLEN  IF/ID instruction to decode.
- PC_n  output  XLEN  IF/ID copy of PC_new for the fetched instruction.

Behaviour:
- Reset is asynchronous, active-low. While reset==0, immediately:
  - PC=RESET_PC;
  - instr=NOP_INSTR;
  - PC_n=0.
- Outputs hold these values until the first rising edge after reset returns to 1.
- PC_new = PC + PC_INC:
  - purely combinational;
  - modulo 2^XLEN, so 32'hFFFF_FFFC wraps to 0.
- PC register update at each rising edge, first matching condition wins:
  - branch_taken=1: PC <= {branch_target[XLEN-1:2],2'b00}. Low bits are forced to zero; redirect overrides stall.
  - stall=1: PC holds.
  - otherwise: PC <= PC_new.
- IF/ID register update at each rising edge, first matching condition wins:
  - flush=1: instr <= NOP_INSTR, PC_n <= 0. Flush overrides stall.
  - stall=1: instr and PC_n hold.
  - otherwise: instr <= instruction, PC_n <= PC_new.
- Latency: instruction fetched at PC appears on instr one cycle later; PC_n then equals that PC+4.
- In steady state (no stall/flush/branch), PC_n equals the updated PC, and PC advances by 4 each cycle: 0,4,8,...
- Reset asserted mid-operation: outputs return to reset values immediately, regardless of stall/flush/branch.
- Simultaneous branch_taken and flush (normal taken-branch case):
  - PC loads the target;
  - IF/ID receives a bubble.
- All storage is flip-flops; no latches; no combinational path from instruction to PC.

Optional Feature:
- Macro: IF_STAGE_PC_CUR_EN.
- With the macro defined:
  - adds output port PC_cur (XLEN), the IF/ID copy of PC for the fetched instruction;
  - PC_cur resets to 0 and clears to 0 on flush;
  - PC_cur holds on stall and otherwise loads PC, with the same priority rules as PC_n.
- Without the macro: port and register are absent; all other behaviour is identical.

Test Plan:
- Reset release: hold reset=0 for 20 ns, release, run 10 cycles -> PC=0,4,8,...,0x28; instr=NOP_INSTR until the first post-reset edge; then instr=imem[PC-4] and PC_n=current PC.
- Stall: assert stall for 2 cycles at PC=0x10 -> PC stays 0x10, instr/PC_n hold; after release PC=0x14.
- Branch with flush: branch_taken=1, flush=1, branch_target=0x103 at PC=0x20 -> next PC=0x100, instr=NOP_INSTR, PC_n=0; following cycle instr=imem[0x100], PC_n=0x104.
- Flush beats stall, branch beats stall: stall=1 with flush=1 -> IF/ID bubbles; stall=1 with branch_taken=1 -> PC loads target.
- Wrap-around: force PC to 0xFFFF_FFFC via branch -> PC_new=0x0, next PC=0x0.
- Async reset mid-run: pull reset low between clock edges at PC=0x40 -> PC=0, instr=NOP_INSTR, PC_n=0 without waiting for a clock edge; if IF_STAGE_PC_CUR_EN is defined, PC_cur=0 as well.

Source files
------------

// File: rtl/if_stage.sv
// if_stage: instruction-fetch stage of the 5-stage RISC-V pipeline.
// Holds the program counter, computes PC + PC_INC, and registers the fetched
// instruction together with its PC + PC_INC into the IF/ID pipeline register.
// Optional: define IF_STAGE_PC_CUR_EN to add PC_cur, the IF/ID copy of the
// fetch PC itself.
module if_stage #(
    parameter int              XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = 32'h0000_0000,
    parameter int              PC_INC    = 4,
    parameter logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] instruction,
    input  logic            stall,
    input  logic            flush,
    input  logic            branch_taken,
    input  logic [XLEN-1:0] branch_target,
    output logic [XLEN-1:0] PC,
    output logic [XLEN-1:0] PC_new,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] PC_n
`ifdef IF_STAGE_PC_CUR_EN
    ,
    output logic [XLEN-1:0] PC_cur
`endif
);

    localparam logic [XLEN-1:0] PC_INC_W = XLEN'(PC_INC);

    logic [XLEN-1:0] pc_reg;
    logic [XLEN-1:0] instr_reg;
    logic [XLEN-1:0] pc_n_reg;
    logic [XLEN-1:0] redirect_pc;

    // Incrementer wraps naturally at 2^XLEN; redirect targets are word-aligned.
    always_comb begin
        PC_new      = pc_reg + PC_INC_W;
        redirect_pc = {branch_target[XLEN-1:2], 2'b00};
    end

    // Program counter: a redirect wins over a stall so a taken branch is never lost.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_reg <= RESET_PC;
        end else if (branch_taken) begin
            pc_reg <= redirect_pc;
        end else if (!stall) begin
            pc_reg <= PC_new;
        end
    end

    // IF/ID register: flush wins over stall so a squashed slot always becomes a bubble.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instr_reg <= NOP_INSTR;
            pc_n_reg  <= '0;
        end else if (flush) begin
            instr_reg <= NOP_INSTR;
            pc_n_reg  <= '0;
        end else if (!stall) begin
            instr_reg <= instruction;
            pc_n_reg  <= PC_new;
        end
    end

`ifdef IF_STAGE_PC_CUR_EN
    logic [XLEN-1:0] pc_cur_reg;

    // IF/ID copy of the fetch PC, following the same flush/stall priority as PC_n.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_cur_reg <= '0;
        end else if (flush) begin
            pc_cur_reg <= '0;
        end else if (!stall) begin
            pc_cur_reg <= pc_reg;
        end
    end

    assign PC_cur = pc_cur_reg;
`endif

    assign PC    = pc_reg;
    assign instr = instr_reg;
    assign PC_n  = pc_n_reg;

endmodule

// File: tb/tb_if_stage.sv
// tb_if_stage: self-checking bench for if_stage. A word-addressed hash stands in
// for the combinational instruction memory; a small reference model tracks the
// architectural PC and the IF/ID contents.
module tb_if_stage;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        reset;
    logic [31:0] instruction;
    logic        stall;
    logic        flush;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] PC;
    logic [31:0] PC_new;
    logic [31:0] instr;
    logic [31:0] PC_n;
`ifdef IF_STAGE_PC_CUR_EN
    logic [31:0] PC_cur;
`endif

    int vectors;
    int miscompares;

    // Reference state
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_pc_n;
    logic [31:0] m_pc_cur;

    if_stage dut (
        .clk          (clk),
        .reset        (reset),
        .instruction  (instruction),
        .stall        (stall),
        .flush        (flush),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .PC           (PC),
        .PC_new       (PC_new),
        .instr        (instr),
        .PC_n         (PC_n)
`ifdef IF_STAGE_PC_CUR_EN
        ,
        .PC_cur       (PC_cur)
`endif
    );

    function automatic logic [31:0] imem(input logic [31:0] addr);
        return (addr * 32'h9E37_79B1) ^ 32'h5BD1_E995;
    endfunction

    assign instruction = imem(PC);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check_value({tag, ".PC"}, PC, m_pc);
        check_value({tag, ".PC_new"}, PC_new, m_pc + 32'd4);
        check_value({tag, ".instr"}, instr, m_instr);
        check_value({tag, ".PC_n"}, PC_n, m_pc_n);
`ifdef IF_STAGE_PC_CUR_EN
        check_value({tag, ".PC_cur"}, PC_cur, m_pc_cur);
`endif
        $display("[%0t] %s st=%0b fl=%0b br=%0b tgt=%08h -> PC=%08h instr=%08h PC_n=%08h",
                 $time, tag, stall, flush, branch_taken, branch_target, PC, instr, PC_n);
    endtask

    task automatic model_reset();
        m_pc     = 32'h0;
        m_instr  = NOP;
        m_pc_n   = 32'h0;
        m_pc_cur = 32'h0;
    endtask

    // One clock: drive at the falling edge, advance the model at the rising
    // edge, check at the next falling edge.
    task automatic cycle(input string tag, input logic st, input logic fl,
                         input logic br, input logic [31:0] tgt);
        logic [31:0] old_pc;
        stall         = st;
        flush         = fl;
        branch_taken  = br;
        branch_target = tgt;
        @(posedge clk);
        if (reset) begin
            old_pc = m_pc;
            if (br)       m_pc = tgt & ~32'd3;
            else if (!st) m_pc = old_pc + 32'd4;
            if (fl) begin
                m_instr  = NOP;
                m_pc_n   = 32'h0;
                m_pc_cur = 32'h0;
            end else if (!st) begin
                m_instr  = imem(old_pc);
                m_pc_n   = old_pc + 32'd4;
                m_pc_cur = old_pc;
            end
        end
        @(negedge clk);
        check_all(tag);
    endtask

    initial begin
        vectors       = 0;
        miscompares   = 0;
        reset         = 1'b0;
        stall         = 1'b0;
        flush         = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 32'h0;
        model_reset();

        // Reset held: outputs at reset values without any dependence on edges.
        #12;
        check_all("reset_hold");
        #8;
        reset = 1'b1;                 // released at 20 ns, a falling edge
        #1;
        check_all("reset_release");

        // Sequential fetch 0 -> 0x28.
        for (int i = 0; i < 10; i++) cycle("seq", 1'b0, 1'b0, 1'b0, 32'h0);
        check_value("seq_end_pc", PC, 32'h28);

        // Redirect to 0x10 then stall two cycles there.
        cycle("goto_10", 1'b0, 1'b0, 1'b1, 32'h10);
        cycle("stall1", 1'b1, 1'b0, 1'b0, 32'h0);
        cycle("stall2", 1'b1, 1'b0, 1'b0, 32'h0);
        check_value("stall_pc", PC, 32'h10);
        cycle("unstall", 1'b0, 1'b0, 1'b0, 32'h0);
        check_value("unstall_pc", PC, 32'h14);

        // Advance to 0x20 then taken branch with flush to misaligned 0x103.
        for (int i = 0; i < 3; i++) cycle("seq2", 1'b0, 1'b0, 1'b0, 32'h0);
        check_value("pre_branch_pc", PC, 32'h20);
        cycle("br_flush", 1'b0, 1'b1, 1'b1, 32'h103);
        check_value("br_pc", PC, 32'h100);
        check_value("br_bubble", instr, NOP);
        cycle("after_br", 1'b0, 1'b0, 1'b0, 32'h0);
        check_value("after_br_instr", instr, imem(32'h100));
        check_value("after_br_pc_n", PC_n, 32'h104);

        // Priority: flush over stall, branch over stall.
        cycle("flush_stall", 1'b1, 1'b1, 1'b0, 32'h0);
        check_value("flush_stall_instr", instr, NOP);
        cycle("br_stall", 1'b1, 1'b0, 1'b1, 32'h0000_0800);
        check_value("br_stall_pc", PC, 32'h800);

        // Wrap-around at the top of the address space.
        cycle("to_top", 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF);
        check_value("top_pc_new", PC_new, 32'h0);
        cycle("wrap", 1'b0, 1'b0, 1'b0, 32'h0);
        check_value("wrap_pc", PC, 32'h0);

        // Run to 0x40, then assert reset between clock edges.
        for (int i = 0; i < 16; i++) cycle("seq3", 1'b0, 1'b0, 1'b0, 32'h0);
        check_value("pre_reset_pc", PC, 32'h40);
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check_all("async_reset");
        // Held through an edge with busy controls: nothing may move.
        cycle("reset_busy", 1'b1, 1'b0, 1'b1, 32'h1234_5678);
        reset = 1'b1;
        #1;
        check_all("reset_release2");

        // Randomized phase.
        for (int i = 0; i < 300; i++) begin
            logic        st, fl, br;
            logic [31:0] tgt;
            st  = ($urandom_range(0, 3) == 0);
            fl  = ($urandom_range(0, 7) == 0);
            br  = ($urandom_range(0, 7) == 0);
            tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | $urandom_range(0, 15))
                                              : $urandom;
            if (br && $urandom_range(0, 1) == 1) fl = 1'b1;
            cycle("rand", st, fl, br, tgt);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
